// File: rtl/axis_sa_feeder.sv
// Joins the X and K streams into the systolic array's beat stream,
// marking tile boundaries and sequencing a job of tiles behind a skid buffer.
module axis_sa_feeder #(
    parameter int Rows     = 4,
    parameter int Cols     = 8,
    parameter int WidthX   = 4,
    parameter int WidthK   = 8,
    parameter int MaxK     = 1024,
    parameter int MaxTiles = 65535,
    parameter int WidthKc  = $clog2(MaxK + 1),
    parameter int WidthT   = $clog2(MaxTiles + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [WidthKc-1:0]            cfg_k_i,
    input  logic [WidthT-1:0]             cfg_tiles_i,
    input  logic                          sx_valid_i,
    output logic                          sx_ready_o,
    input  logic [Rows-1:0][WidthX-1:0]   sx_data_i,
    input  logic                          sk_valid_i,
    output logic                          sk_ready_o,
    input  logic [Cols-1:0][WidthK-1:0]   sk_data_i,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          m_last_o,
    output logic [Rows-1:0][WidthX-1:0]   mx_data_o,
    output logic [Cols-1:0][WidthK-1:0]   mk_data_o,
    output logic                          busy_o,
    output logic                          done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam logic [WidthKc-1:0] OneK = 1;
    localparam logic [WidthT-1:0]  OneT = 1;

    state_e state_q, state_d;
    logic [WidthKc-1:0] k_q, k_d, beat_q, beat_d;
    logic [WidthT-1:0]  tiles_q, tiles_d, tile_q, tile_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [Rows-1:0][WidthX-1:0] x0_q, x0_d, x1_q, x1_d;
    logic [Cols-1:0][WidthK-1:0] k0_q, k0_d, k1_q, k1_d;
    logic l0_q, l0_d, l1_q, l1_d;
    logic join_w, last_w, pop_w, free_w;

    assign free_w = (cnt_q != 2'd2);
    assign pop_w  = (cnt_q != 2'd0) && m_ready_i;
    assign last_w = (beat_q == k_q - OneK);

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        tiles_d     = tiles_q;
        beat_d      = beat_q;
        tile_d      = tile_q;
        join_w      = 1'b0;
        cfg_ready_o = 1'b0;
        done_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) begin
                    k_d     = cfg_k_i;
                    tiles_d = cfg_tiles_i;
                    beat_d  = '0;
                    tile_d  = '0;
                    if (cfg_k_i == '0 || cfg_tiles_i == '0) state_d = DONE;
                    else state_d = RUN;
                end
            end
            RUN: begin
                join_w = sx_valid_i && sk_valid_i && free_w;
                if (join_w) begin
                    if (last_w) begin
                        beat_d = '0;
                        tile_d = tile_q + OneT;
                        if (tile_q == tiles_q - OneT) state_d = DRAIN;
                    end else begin
                        beat_d = beat_q + OneK;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == 2'd0) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Head entry (x0/k0/l0) always drives the array; x1 holds the overflow beat.
    always_comb begin
        cnt_d = cnt_q;
        x0_d  = x0_q;
        x1_d  = x1_q;
        k0_d  = k0_q;
        k1_d  = k1_q;
        l0_d  = l0_q;
        l1_d  = l1_q;
        case (cnt_q)
            2'd0: begin
                if (join_w) begin
                    x0_d  = sx_data_i;
                    k0_d  = sk_data_i;
                    l0_d  = last_w;
                    cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (join_w && pop_w) begin
                    x0_d = sx_data_i;
                    k0_d = sk_data_i;
                    l0_d = last_w;
                end else if (join_w) begin
                    x1_d  = sx_data_i;
                    k1_d  = sk_data_i;
                    l1_d  = last_w;
                    cnt_d = 2'd2;
                end else if (pop_w) begin
                    cnt_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop_w) begin
                    x0_d  = x1_q;
                    k0_d  = k1_q;
                    l0_d  = l1_q;
                    cnt_d = 2'd1;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            tiles_q <= '0;
            beat_q  <= '0;
            tile_q  <= '0;
            cnt_q   <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            k0_q    <= '0;
            k1_q    <= '0;
            l0_q    <= 1'b0;
            l1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            tiles_q <= tiles_d;
            beat_q  <= beat_d;
            tile_q  <= tile_d;
            cnt_q   <= cnt_d;
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
        end
    end

    assign sx_ready_o = join_w;
    assign sk_ready_o = join_w;
    assign m_valid_o  = (cnt_q != 2'd0);
    assign m_last_o   = l0_q && m_valid_o;
    assign mx_data_o  = x0_q;
    assign mk_data_o  = k0_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_axis_sa_feeder.sv
// Bench for axis_sa_feeder: random lane data, expected beat order and
// tile boundaries derived from the configured k and tile count.
module tb_axis_sa_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [10:0] cfg_k;
    logic [15:0] cfg_tiles;
    logic        sx_valid, sx_ready;
    logic [15:0] sx_data;
    logic        sk_valid, sk_ready;
    logic [63:0] sk_data;
    logic        m_valid, m_ready, m_last;
    logic [15:0] mx_data;
    logic [63:0] mk_data;
    logic        busy, done;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axis_sa_feeder dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .cfg_k_i     (cfg_k),
        .cfg_tiles_i (cfg_tiles),
        .sx_valid_i  (sx_valid),
        .sx_ready_o  (sx_ready),
        .sx_data_i   (sx_data),
        .sk_valid_i  (sk_valid),
        .sk_ready_o  (sk_ready),
        .sk_data_i   (sk_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_last_o    (m_last),
        .mx_data_o   (mx_data),
        .mk_data_o   (mk_data),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " m_valid"}, m_valid, 0);
        check({tag, " m_last"}, m_last, 0);
        check({tag, " mx_data"}, mx_data, 0);
        check({tag, " mk_data"}, mk_data, 0);
        check({tag, " sx_ready"}, sx_ready, 0);
        check({tag, " sk_ready"}, sk_ready, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " cfg_ready"}, cfg_ready, 1);
    endtask

    // mode 0: all valid, ready high; 1: K delayed 5 cycles;
    // 2: m_ready pattern 1,0,0,1; 3: random valids and ready
    task automatic run_job(input int k, input int t, input int mode);
        logic [15:0] xq[$];
        logic [63:0] kq[$];
        logic [15:0] xe[$];
        logic [63:0] ke[$];
        bit          le[$];
        int n, got, donecyc, ndone, fj, fp, lp, outst;
        bit pv, pr, pl, fin;
        logic [15:0] px;
        logic [63:0] pk;
        n = k * t;
        for (int i = 0; i < n; i++) begin
            logic [15:0] xv;
            logic [63:0] kv;
            xv = 16'($urandom);
            kv = {$urandom, $urandom};
            xq.push_back(xv);
            kq.push_back(kv);
            xe.push_back(xv);
            ke.push_back(kv);
            le.push_back((i % k) == k - 1);
        end
        cfg_valid = 1'b1;
        cfg_k     = 11'(k);
        cfg_tiles = 16'(t);
        @(negedge clk);
        check("cfg_ready idle", cfg_ready, 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        fj = -1; fp = -1; lp = -1; donecyc = -1;
        ndone = 0; got = 0; outst = 0;
        pv = 0; pr = 0; pl = 0; px = '0; pk = '0; fin = 0;
        for (int c = 0; c < 2000 && !fin; c++) begin
            case (mode)
                1: begin
                    sx_valid = xq.size() > 0;
                    sk_valid = kq.size() > 0 && c >= 5;
                    m_ready  = 1'b1;
                end
                2: begin
                    sx_valid = xq.size() > 0;
                    sk_valid = kq.size() > 0;
                    m_ready  = (c % 4 == 0) || (c % 4 == 3);
                end
                3: begin
                    sx_valid = xq.size() > 0 && $urandom_range(0, 3) != 0;
                    sk_valid = kq.size() > 0 && $urandom_range(0, 3) != 0;
                    m_ready  = $urandom_range(0, 1) == 1;
                end
                default: begin
                    sx_valid = xq.size() > 0;
                    sk_valid = kq.size() > 0;
                    m_ready  = 1'b1;
                end
            endcase
            sx_data = xq.size() > 0 ? xq[0] : 16'h0;
            sk_data = kq.size() > 0 ? kq[0] : 64'h0;
            @(negedge clk);
            if (pv && !pr) begin
                check("stall valid", m_valid, 1);
                check("stall x", mx_data, px);
                check("stall k", mk_data, pk);
                check("stall last", m_last, pl);
            end
            if (m_valid && m_ready) begin
                if (xe.size() == 0) begin
                    check("extra beat", 1, 0);
                end else begin
                    check("beat x", mx_data, xe.pop_front());
                    check("beat k", mk_data, ke.pop_front());
                    check("beat last", m_last, le.pop_front());
                end
                got++;
                outst--;
                if (fp < 0) fp = c;
                lp = c;
            end
            check("ready pair", sx_ready, sk_ready);
            if (mode == 1 && c < 5) check("x held", sx_ready, 0);
            if (sx_ready) begin
                check("join needs both valid", sx_valid && sk_valid, 1);
                if (fj < 0) fj = c;
                if (xq.size() > 0) begin
                    void'(xq.pop_front());
                    void'(kq.pop_front());
                end
                outst++;
            end
            if (outst > 2) check("outstanding", outst, 2);
            if (done) begin
                ndone++;
                donecyc = c;
                check("done after beats", got, n);
            end
            if (ndone > 0 && c > donecyc) begin
                check("busy after done", busy, 0);
                fin = 1;
            end
            pv = m_valid; pr = m_ready; pl = m_last;
            px = mx_data; pk = mk_data;
            @(posedge clk);
            #1;
        end
        sx_valid = 1'b0;
        sk_valid = 1'b0;
        m_ready  = 1'b1;
        if (!fin) check("timeout", 0, 1);
        check("done pulses", ndone, 1);
        check("beats seen", got, n);
        check("cfg_ready back", cfg_ready, 1);
        if (n == 0) check("zero job done cycle", donecyc, 0);
        if (mode == 0 && n > 0) begin
            check("first beat latency", fp, fj + 1);
            check("throughput", lp - fp, n - 1);
            check("done after last pop", donecyc > lp, 1);
        end
    endtask

    initial begin
        int cons;
        rst = 1'b1;
        cfg_valid = 0; cfg_k = 0; cfg_tiles = 0;
        sx_valid = 0; sx_data = 0;
        sk_valid = 0; sk_data = 0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_job(4, 2, 0);
        run_job(3, 1, 1);
        run_job(5, 1, 2);
        run_job(0, 3, 0);
        run_job(4, 0, 0);
        run_job(1, 4, 0);
        run_job(7, 3, 3);

        // reset in the middle of a k=6 tile
        cfg_valid = 1'b1;
        cfg_k     = 11'd6;
        cfg_tiles = 16'd1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        cons = 0;
        for (int c = 0; c < 50 && cons < 2; c++) begin
            sx_valid = 1'b1;
            sk_valid = 1'b1;
            sx_data  = 16'($urandom);
            sk_data  = {$urandom, $urandom};
            @(negedge clk);
            if (sx_ready) cons++;
            @(posedge clk);
            #1;
        end
        check("mid-tile beats joined", cons, 2);
        check("busy before reset", busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async reset");
        @(posedge clk);
        @(negedge clk);
        check("no done in reset", done, 0);
        rst = 1'b0;
        sx_valid = 1'b0;
        sk_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle after reset", busy, 0);
        run_job(2, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
